// File: rtl/serial_twos_complement.sv
// rtl/serial_twos_complement.sv - bit-serial one's/two's complement unit, LSB first, WIDTH+1-bit result.
// Optional TWOS_COMP_ABS_EN adds an abs_mode input (absolute value through the same serial path).
module serial_twos_complement #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
`ifdef TWOS_COMP_ABS_EN
  input  logic             abs_mode,
`endif
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH:0]   result,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic [1:0] {OP_ONES, OP_TWOS, OP_COPY} op_t;

  state_t         state_q;
  op_t            op_q;
  op_t            op_d;
  logic [WIDTH:0] sr_q;
  logic [WIDTH:0] result_q;
  logic [CW-1:0]  cnt_q;
  logic           seen_q;
  logic           busy_q;
  logic           done_q;
  logic           ovf_q;
  logic           ovf_d;
  logic           out_bit;

  // Operation is resolved once at the accepted start so the serial path only needs the latched op.
  always_comb begin
    op_d = mode ? OP_TWOS : OP_ONES;
`ifdef TWOS_COMP_ABS_EN
    if (abs_mode) begin
      op_d = a[WIDTH-1] ? OP_TWOS : OP_COPY;
    end
`endif
    ovf_d = (op_d == OP_TWOS) && (a == MOST_NEG);
  end

  always_comb begin
    out_bit = 1'b0;
    case (op_q)
      OP_ONES: out_bit = ~sr_q[0];
      OP_TWOS: out_bit = seen_q ? ~sr_q[0] : sr_q[0];
      OP_COPY: out_bit = sr_q[0];
      default: out_bit = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= OP_ONES;
      sr_q     <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      seen_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            sr_q    <= {a[WIDTH-1], a};
            op_q    <= op_d;
            ovf_q   <= ovf_d;
            cnt_q   <= '0;
            seen_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          result_q <= {out_bit, result_q[WIDTH:1]};
          sr_q     <= sr_q >> 1;
          seen_q   <= seen_q | sr_q[0];
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH)) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign result = result_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign ovf    = ovf_q;

endmodule

// File: doc/serial_twos_complement.md
Name: serial_twos_complement

Overview:
Parametrised, bit-serial negation unit for the ALU datapath; successor to the combinational 3-bit complement block. Accepts a signed WIDTH-bit operand and produces its one's or two's complement as a sign-extended WIDTH+1-bit result. Processes one bit per clock, LSB first, using copy-until-first-1-then-invert. A start/busy/done handshake lets the ALU controller sequence it alongside other multi-cycle units.

Parameters:
WIDTH, 4, operand width in bits; minimum 2; result width is WIDTH+1.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset
start  input  1  request; sampled only in IDLE
mode  input  1  0 = one's complement, 1 = two's complement
a  input  WIDTH  signed operand; sampled on the accepted start edge only
result  output  WIDTH+1  sign-extended complement; registered, held until next accepted start
busy  output  1  high while bits are being processed
done  output  1  one-cycle pulse; result/ovf valid from this cycle on
ovf  output  1  result not representable in WIDTH bits; valid with done, held with result

Behaviour:
- Reset (rst_n low, async, any state): state=IDLE; result=0; busy=0; done=0; ovf=0; bit counter=0; shift register=0; seen_one=0.
- States: IDLE, BUSY, DONE.
- IDLE: start=1 at edge k -> load shift register with {a[WIDTH-1], a} (sign-extended); latch mode; counter=0; seen_one=0; compute ovf; state->BUSY. start=0 -> stay; outputs hold.
- BUSY: each edge consumes shift-register LSB b and shifts it out:
  - mode 0: out bit = ~b.
  - mode 1: out bit = seen_one ? ~b : b; then seen_one |= b.
  - out bit shifts into result MSB (result fills LSB-first via right shift); counter++.
  - After the edge that processes bit WIDTH (the (WIDTH+1)th bit), state->DONE.
- DONE: done=1 for exactly one cycle; next edge -> IDLE unconditionally.
- busy=1 exactly in BUSY; done=1 exactly in DONE.
- Latency: start sampled at edge k -> busy high after edges k+1..k+WIDTH+1 -> done high in the cycle following edge k+WIDTH+1 (WIDTH+1 processing cycles). Next start accepted at edge k+WIDTH+3 at the earliest.
- result is intermediate (partially shifted) while busy; consumers use it only from done onward. After DONE, result holds until the next accepted start.
- ovf: mode 1 and a == {1'b1, {WIDTH-1{1'b0}}} (most negative) -> ovf=1 (the WIDTH+1-bit result is still correct, e.g. +8 for WIDTH=4). Mode 0 -> ovf=0. ovf registered at load, held with result.
- a=0, mode 1 -> result 0, ovf=0 (seen_one never set; all bits copied).
- start while BUSY or DONE: ignored, no queuing. a and mode changes during BUSY: no effect.
- rst_n asserted mid-operation: immediate abort to reset values; no done pulse.

Optional Feature:
Macro TWOS_COMP_ABS_EN.
- Defined: extra input abs_mode (1 bit). When abs_mode=1 at the accepted start, the operand is negated (two's complement, mode ignored) only if a[WIDTH-1]=1; otherwise copied unchanged (sign-extended) through the same WIDTH+1-cycle serial path, identical latency. ovf=1 only for the most-negative operand. abs_mode=0 -> behaviour exactly as without the macro.
- Undefined: no abs_mode port; behaviour as specified above.

Test Plan:
- WIDTH=4, reset then mode=1, a=4'b0011, start 1 cycle -> busy 5 cycles, done 1 cycle, result=5'b11101, ovf=0.
- mode=1, a=4'b1000 -> result=5'b01000 (+8), ovf=1; mode=0, a=4'b0101 -> result=5'b11010, ovf=0.
- mode=1, a=4'b0000 -> result=5'b00000, ovf=0; mode=1, a=4'b1111 -> result=5'b00001.
- Operation started with a=4'b0011; start pulsed with a=4'b0110 during BUSY -> ignored, result=5'b11101; result holds after done until next start; back-to-back start accepted exactly 2 cycles after the last BUSY cycle.
- rst_n low on 3rd BUSY cycle -> busy, done, result, ovf immediately 0; no done pulse; next start completes normally.
- With TWOS_COMP_ABS_EN, abs_mode=1: a=4'b1101 -> 5'b00011, ovf=0; a=4'b0110 -> 5'b00110; a=4'b1000 -> 5'b01000, ovf=1; latency unchanged.
